// File: rtl/ptp_intc_pkg.sv
// Shared constants for the PTP multi-source interrupt controller: register
// offsets, COAL field layout/reset value and coalescing FSM encoding.
package ptp_intc_pkg;

    localparam logic [4:0] OFF_STATUS = 5'h00;
    localparam logic [4:0] OFF_MASK   = 5'h04;
    localparam logic [4:0] OFF_RAW    = 5'h08;
    localparam logic [4:0] OFF_COAL   = 5'h0C;
    localparam logic [4:0] OFF_MODE   = 5'h10;

    localparam int COAL_TH_LSB = 0;
    localparam int COAL_TH_MSB = 7;
    localparam int COAL_TO_LSB = 16;
    localparam int COAL_TO_MSB = 31;

    localparam logic [31:0] COAL_RST = 32'h0000_0001;
    localparam logic [7:0]  CNT_MAX  = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } coal_state_e;

endpackage

// File: rtl/ptp_intc_sync.sv
// One-source synchroniser into bus2ip_clk with a rising-edge detect flop
// behind the last synchroniser stage.
module ptp_intc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic bus2ip_clk,
    input  logic bus2ip_rst_n,
    input  logic src_i,
    output logic level_o,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ptp_int_ctl_mc.sv
// NUM_SRC-input PTP interrupt controller on the 32-bit bus2ip slave port.
// Interrupt coalescing FSM is built only when PTP_INTC_COALESCE_EN is defined.
module ptp_int_ctl_mc
    import ptp_intc_pkg::*;
#(
    parameter int          NUM_SRC       = 8,
    parameter logic [31:0] INT_BASE_ADDR = 32'h300,
    parameter int          SYNC_STAGES   = 2,
    parameter int          TMR_W         = 16
) (
    input  logic               bus2ip_clk,
    input  logic               bus2ip_rst_n,
    input  logic [31:0]        bus2ip_addr_i,
    input  logic [31:0]        bus2ip_data_i,
    input  logic               bus2ip_rd_ce_i,
    input  logic               bus2ip_wr_ce_i,
    output logic [31:0]        ip2bus_data_o,
    input  logic [NUM_SRC-1:0] int_src_i,
    output logic [NUM_SRC-1:0] int_pending_o,
    output logic               int_ptp_o
);
    logic               hit;
    logic [4:0]         off;
    logic               wr_status, wr_mask, wr_mode;
    logic [NUM_SRC-1:0] lvl, rise, set_vec, w1c;
    logic [NUM_SRC-1:0] status_q, status_d, mask_q, mask_d, mode_q, mode_d;
    logic [NUM_SRC-1:0] pend_d, pending_q;
    logic [31:0]        rd_data, coal_rd, ip2bus_data_q;
    logic               int_q, int_d;

    assign hit       = (bus2ip_addr_i[31:5] == INT_BASE_ADDR[31:5]);
    assign off       = bus2ip_addr_i[4:0];
    assign wr_status = bus2ip_wr_ce_i && hit && (off == OFF_STATUS);
    assign wr_mask   = bus2ip_wr_ce_i && hit && (off == OFF_MASK);
    assign wr_mode   = bus2ip_wr_ce_i && hit && (off == OFF_MODE);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        ptp_intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .bus2ip_clk   (bus2ip_clk),
            .bus2ip_rst_n (bus2ip_rst_n),
            .src_i        (int_src_i[g]),
            .level_o      (lvl[g]),
            .rise_o       (rise[g])
        );
    end

    // Set is OR-ed in after the clear so a coincident event beats the W1C.
    assign set_vec  = (mode_q & lvl) | (~mode_q & rise);
    assign w1c      = wr_status ? bus2ip_data_i[NUM_SRC-1:0] : '0;
    assign status_d = (status_q & ~w1c) | set_vec;
    assign mask_d   = wr_mask ? bus2ip_data_i[NUM_SRC-1:0] : mask_q;
    assign mode_d   = wr_mode ? bus2ip_data_i[NUM_SRC-1:0] : mode_q;
    assign pend_d   = status_q & mask_q;

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_STATUS: rd_data[NUM_SRC-1:0] = status_q;
            OFF_MASK:   rd_data[NUM_SRC-1:0] = mask_q;
            OFF_RAW:    rd_data[NUM_SRC-1:0] = lvl;
            OFF_COAL:   rd_data              = coal_rd;
            OFF_MODE:   rd_data[NUM_SRC-1:0] = mode_q;
            default:    rd_data              = '0;
        endcase
    end

    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            status_q      <= '0;
            mask_q        <= '0;
            mode_q        <= '0;
            pending_q     <= '0;
            ip2bus_data_q <= '0;
            int_q         <= 1'b0;
        end else begin
            status_q      <= status_d;
            mask_q        <= mask_d;
            mode_q        <= mode_d;
            pending_q     <= pend_d;
            ip2bus_data_q <= (bus2ip_rd_ce_i && hit) ? rd_data : '0;
            int_q         <= int_d;
        end
    end

`ifdef PTP_INTC_COALESCE_EN
    localparam logic [TMR_W-1:0] TMR_MAX = '1;

    coal_state_e      state_q, state_d;
    logic [7:0]       th_q, cnt_q, cnt_d;
    logic [15:0]      to_q;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             wr_coal, new_any, pend_any, held;

    assign wr_coal  = bus2ip_wr_ce_i && hit && (off == OFF_COAL);
    // A masked bit is "new" when it is pending next cycle but not this one.
    assign new_any  = |(status_d & mask_d & ~pend_d);
    assign pend_any = |pend_d;

    always_comb begin
        coal_rd = '0;
        coal_rd[COAL_TH_MSB:COAL_TH_LSB] = th_q;
        coal_rd[COAL_TO_MSB:COAL_TO_LSB] = to_q;
    end

    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            th_q    <= COAL_RST[COAL_TH_MSB:COAL_TH_LSB];
            to_q    <= COAL_RST[COAL_TO_MSB:COAL_TO_LSB];
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            if (wr_coal) begin
                th_q <= bus2ip_data_i[COAL_TH_MSB:COAL_TH_LSB];
                to_q <= bus2ip_data_i[COAL_TO_MSB:COAL_TO_LSB];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        held    = 1'b0;
        int_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_any) begin
                    state_d = ST_HOLD;
                    cnt_d   = 8'd1;
                    tmr_d   = '0;
                end
            end
            ST_HOLD: begin
                if (int_q && !pend_any) begin
                    // Serviced; an event landing in this same cycle opens a new window.
                    state_d = new_any ? ST_HOLD : ST_IDLE;
                    cnt_d   = new_any ? 8'd1 : 8'd0;
                    tmr_d   = '0;
                end else begin
                    held = int_q;
                    if (new_any && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 8'd1;
                    if (tmr_q != TMR_MAX)              tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_HOLD) begin
            int_d = held || (cnt_d >= th_q) ||
                    ((to_q != 16'd0) && (32'(tmr_d) >= 32'(to_q)));
        end
    end
`else
    assign coal_rd = '0;
    assign int_d   = |pend_d;
`endif

    assign ip2bus_data_o = ip2bus_data_q;
    assign int_pending_o = pending_q;
    assign int_ptp_o     = int_q;

endmodule

// File: tb/tb_ptp_int_ctl_mc.sv
// Bench for ptp_int_ctl_mc: directed scenarios plus randomized bus/source
// traffic checked cycle by cycle against a register-level reference model.
module tb_ptp_int_ctl_mc;
    localparam int          N    = 8;
    localparam int          S    = 2;
    localparam logic [31:0] BASE = 32'h300;
`ifdef PTP_INTC_COALESCE_EN
    localparam int          LAT_INT  = S + 1;
    localparam logic [31:0] COAL_RST = 32'h0000_0001;
`else
    localparam int          LAT_INT  = S + 2;
    localparam logic [31:0] COAL_RST = 32'h0000_0000;
`endif

    logic          bus2ip_clk = 1'b0;
    logic          bus2ip_rst_n = 1'b1;
    logic [31:0]   bus2ip_addr_i, bus2ip_data_i, ip2bus_data_o;
    logic          bus2ip_rd_ce_i, bus2ip_wr_ce_i;
    logic [N-1:0]  int_src_i, int_pending_o;
    logic          int_ptp_o;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    ptp_int_ctl_mc #(
        .NUM_SRC(N), .INT_BASE_ADDR(BASE), .SYNC_STAGES(S), .TMR_W(16)
    ) dut (
        .bus2ip_clk     (bus2ip_clk),
        .bus2ip_rst_n   (bus2ip_rst_n),
        .bus2ip_addr_i  (bus2ip_addr_i),
        .bus2ip_data_i  (bus2ip_data_i),
        .bus2ip_rd_ce_i (bus2ip_rd_ce_i),
        .bus2ip_wr_ce_i (bus2ip_wr_ce_i),
        .ip2bus_data_o  (ip2bus_data_o),
        .int_src_i      (int_src_i),
        .int_pending_o  (int_pending_o),
        .int_ptp_o      (int_ptp_o)
    );

    always #5 bus2ip_clk = ~bus2ip_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register contents as seen by software, with the
    // synchroniser modelled as a history of sampled inputs (newest first).
    logic [N-1:0]  m_status, m_mask, m_mode, m_pend, m_lvl, m_prv, m_set, m_w1c;
    logic          m_int, m_hit;
    logic [4:0]    m_off;
    logic [7:0]    m_th;
    logic [15:0]   m_to;
    logic [31:0]   m_rdv;
    logic [N-1:0]  hist[$];
    logic [31:0]   exp_q[$];

    always @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            m_status = '0; m_mask = '0; m_mode = '0; m_pend = '0; m_int = 1'b0;
            m_th = COAL_RST[7:0]; m_to = COAL_RST[31:16];
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back('0);
            exp_q.delete();
        end else begin
            m_lvl = hist[S-1];
            m_prv = hist[S];
            m_hit = (bus2ip_addr_i[31:5] == BASE[31:5]);
            m_off = bus2ip_addr_i[4:0];
            m_rdv = '0;
            if (bus2ip_rd_ce_i && m_hit) begin
                case (m_off)
                    5'h00: m_rdv[N-1:0] = m_status;
                    5'h04: m_rdv[N-1:0] = m_mask;
                    5'h08: m_rdv[N-1:0] = m_lvl;
                    5'h0C: m_rdv = {m_to, 8'h00, m_th};
                    5'h10: m_rdv[N-1:0] = m_mode;
                    default: m_rdv = '0;
                endcase
            end
            exp_q.push_back(m_rdv);
            m_pend = m_status & m_mask;
            m_int  = (m_pend != '0);
            m_set  = (m_mode & m_lvl) | (~m_mode & m_lvl & ~m_prv);
            m_w1c  = (bus2ip_wr_ce_i && m_hit && m_off == 5'h00) ? bus2ip_data_i[N-1:0] : '0;
            m_status = (m_status & ~m_w1c) | m_set;
            if (bus2ip_wr_ce_i && m_hit && m_off == 5'h04) m_mask = bus2ip_data_i[N-1:0];
            if (bus2ip_wr_ce_i && m_hit && m_off == 5'h10) m_mode = bus2ip_data_i[N-1:0];
`ifdef PTP_INTC_COALESCE_EN
            if (bus2ip_wr_ce_i && m_hit && m_off == 5'h0C) begin
                m_th = bus2ip_data_i[7:0];
                m_to = bus2ip_data_i[31:16];
            end
`endif
            hist.push_front(int_src_i);
            void'(hist.pop_back());
        end
    end

    always @(negedge bus2ip_clk) begin
        if (bus2ip_rst_n && chk_en) begin
            check_eq("cyc_pending", int_pending_o, m_pend);
            if (exp_q.size() > 0) check_eq("cyc_rdata", ip2bus_data_o, exp_q.pop_front());
`ifndef PTP_INTC_COALESCE_EN
            check_eq("cyc_int", int_ptp_o, m_int);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge bus2ip_clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus2ip_addr_i = addr; bus2ip_data_i = data; bus2ip_wr_ce_i = 1'b1;
        tick(1);
        bus2ip_wr_ce_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus2ip_addr_i = addr; bus2ip_rd_ce_i = 1'b1;
        tick(1);
        bus2ip_rd_ce_i = 1'b0;
        data = ip2bus_data_o;
    endtask

    task automatic pulse_src(input int idx);
        int_src_i[idx] = 1'b1;
        tick(1);
        int_src_i[idx] = 1'b0;
    endtask

    // Raise a source, drop it after one cycle and count cycles until int_ptp_o.
    task automatic int_latency(input int idx, input int limit, output int k);
        int_src_i[idx] = 1'b1;
        k = limit;
        for (int i = 0; i < limit; i++) begin
            tick(1);
            if (i == 0) int_src_i[idx] = 1'b0;
            if (int_ptp_o) begin
                k = i + 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        bus2ip_rst_n = 1'b0; bus2ip_rd_ce_i = 1'b0; bus2ip_wr_ce_i = 1'b0; int_src_i = '0;
        tick(2);
        check_eq("rst_int", int_ptp_o, 1'b0);
        check_eq("rst_pending", int_pending_o, '0);
        check_eq("rst_rdata", ip2bus_data_o, '0);
        bus2ip_rst_n = 1'b1;
        tick(1);
    endtask

    logic [31:0] rd, rnd;
    int k;

    initial begin
        bus2ip_addr_i = '0; bus2ip_data_i = '0; bus2ip_rd_ce_i = 1'b0;
        bus2ip_wr_ce_i = 1'b0; int_src_i = '0;
        do_reset();
        chk_en = 1'b1;

        bus_read(BASE + 32'h0C, rd);
        check_eq("coal_reset", rd, COAL_RST);

        // Edge source sets STATUS, W1C clears it.
        bus_write(BASE + 32'h04, 32'hFF);
        bus_write(BASE + 32'h10, 32'h00);
        int_latency(3, 20, k);
        check_eq("t1_int_latency", k, LAT_INT);
        bus_read(BASE, rd);
        check_eq("t1_status", rd, 32'h08);
        bus_write(BASE, 32'h08);
        tick(2);
        bus_read(BASE, rd);
        check_eq("t1_status_clr", rd, 32'h0);
        check_eq("t1_int_clr", int_ptp_o, 1'b0);

        // Level source: W1C ignored while high, effective once low.
        bus_write(BASE + 32'h10, 32'h20);
        int_src_i[5] = 1'b1;
        tick(S + 3);
        bus_read(BASE + 32'h08, rd);
        check_eq("t2_raw", rd, 32'h20);
        bus_write(BASE, 32'h20);
        tick(1);
        bus_read(BASE, rd);
        check_eq("t2_status_held", rd, 32'h20);
        int_src_i[5] = 1'b0;
        tick(S + 3);
        bus_write(BASE, 32'h20);
        tick(1);
        bus_read(BASE, rd);
        check_eq("t2_status_clr", rd, 32'h0);
        bus_write(BASE + 32'h10, 32'h00);
        tick(2);

        // Mask gates only the outputs, not capture.
        bus_write(BASE + 32'h04, 32'h00);
        pulse_src(0);
        tick(S + 3);
        bus_read(BASE, rd);
        check_eq("t3_status", rd, 32'h01);
        check_eq("t3_int_masked", int_ptp_o, 1'b0);
        check_eq("t3_pend_masked", int_pending_o, '0);
        bus_write(BASE + 32'h04, 32'h01);
        tick(1);
        check_eq("t3_int_unmasked", int_ptp_o, 1'b1);
        check_eq("t3_pend_unmasked", int_pending_o, 8'h01);
        bus_write(BASE, 32'h01);
        bus_write(BASE + 32'h04, 32'hFF);
        tick(2);

        // A new edge in the same cycle as its W1C keeps the bit set.
        pulse_src(2);
        tick(S + 3);
        int_src_i[2] = 1'b1;
        tick(S);
        bus_write(BASE, 32'h04);
        int_src_i[2] = 1'b0;
        bus_read(BASE, rd);
        check_eq("t4_set_wins", rd, 32'h04);
        bus_write(BASE, 32'h04);
        tick(1);
        bus_read(BASE, rd);
        check_eq("t4_w1c_alone", rd, 32'h0);

        // Unmapped offset and foreign base read zero.
        bus_read(BASE + 32'h14, rd);
        check_eq("t6_unmapped", rd, 32'h0);
        bus_read(32'h400, rd);
        check_eq("t6_other_base0", rd, 32'h0);
        bus_read(32'h404, rd);
        check_eq("t6_other_base4", rd, 32'h0);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            int_src_i = rnd[N-1:0];
            case ($urandom_range(0, 3))
                0: tick(1);
                1: bus_write(BASE + 32'($urandom_range(0, 5) * 4), $urandom());
                2: bus_read(BASE + 32'($urandom_range(0, 5) * 4), rd);
                default: bus_read(32'h400 + 32'($urandom_range(0, 5) * 4), rd);
            endcase
        end

        do_reset();
        bus_write(BASE + 32'h04, 32'hFF);

`ifdef PTP_INTC_COALESCE_EN
        // Count threshold of 3, then a 100-cycle timeout.
        bus_write(BASE + 32'h0C, 32'h0000_0003);
        pulse_src(0);
        tick(S + 4);
        check_eq("t5_cnt1", int_ptp_o, 1'b0);
        pulse_src(1);
        tick(S + 4);
        check_eq("t5_cnt2", int_ptp_o, 1'b0);
        pulse_src(2);
        tick(S + 4);
        check_eq("t5_cnt3", int_ptp_o, 1'b1);
        check_eq("t5_pending", int_pending_o, 8'h07);
        bus_write(BASE, 32'h07);
        tick(3);
        check_eq("t5_serviced", int_ptp_o, 1'b0);
        bus_write(BASE + 32'h0C, 32'h0064_0010);
        bus_read(BASE + 32'h0C, rd);
        check_eq("t5_coal_rd", rd, 32'h0064_0010);
        int_latency(4, 300, k);
        check_eq("t5_timeout_latency", k, S + 101);
`else
        bus_write(BASE + 32'h0C, 32'h0000_0003);
        bus_read(BASE + 32'h0C, rd);
        check_eq("coal_absent", rd, 32'h0);
        pulse_src(4);
        tick(S + 3);
`endif

        // Reset mid-operation clears outputs at once.
        bus_read(BASE, rd);
        check_eq("t6_status_prerst", rd, 32'h10);
        #1;
        bus2ip_rst_n = 1'b0;
        #1;
        check_eq("t6_rst_int", int_ptp_o, 1'b0);
        check_eq("t6_rst_pending", int_pending_o, '0);
        check_eq("t6_rst_rdata", ip2bus_data_o, '0);
        tick(1);
        bus2ip_rst_n = 1'b1;
        tick(1);
        bus_read(BASE + 32'h0C, rd);
        check_eq("t6_coal_after_rst", rd, COAL_RST);
        bus_read(BASE, rd);
        check_eq("t6_status_after_rst", rd, 32'h0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ptp_int_ctl_mc.md
Name: ptp_int_ctl_mc

Overview:
Parametrised multi-source interrupt controller for the PTP NIC. It is the successor to the fixed four-input PTP interrupt controller. It takes NUM_SRC asynchronous interrupt sources (rx/tx buffer, timestamp, xms, and so on) and synchronises each into the bus2ip_clk domain. Per source it adds edge/level mode, sticky W1C status and a mask, plus optional interrupt coalescing. All of this sits on the shared 32-bit on-chip bus, and it drives one combined int_ptp_o.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..32).
- INT_BASE_ADDR, 32'h300, register block base; 32-byte aligned.
- SYNC_STAGES, 2, synchroniser flops per source (>=2).
- TMR_W, 16, coalescing timeout counter width (<=16).

Ports:
- bus2ip_clk  in  1  bus clock; all logic runs on it.
- bus2ip_rst_n  in  1  asynchronous, active-low reset.
- bus2ip_addr_i  in  32  byte address.
- bus2ip_data_i  in  32  write data.
- bus2ip_rd_ce_i  in  1  read strobe, active high, 1 cycle.
- bus2ip_wr_ce_i  in  1  write strobe, active high, 1 cycle.
- ip2bus_data_o  out  32  registered read data; 0 when not addressed.
- int_src_i  in  NUM_SRC  raw asynchronous interrupt inputs.
- int_pending_o  out  NUM_SRC  status & mask, registered.
- int_ptp_o  out  1  combined interrupt, active high, registered.

Behaviour:
- Reset (bus2ip_rst_n low, asynchronous) clears: sync flops, status, mask, mode, timer, event count, ip2bus_data_o, int_pending_o and int_ptp_o. Coalescing register resets to 32'h0000_0001.
- Address hit: addr[31:5]==INT_BASE_ADDR[31:5]. The offset is addr[4:0]; unmapped offsets read 0 and writes to them are ignored.
- Register map (bits >= NUM_SRC read 0):
  - +0x00 STATUS: sticky, W1C.
  - +0x04 MASK: RW; 1 enables the source.
  - +0x08 RAW: RO; synchronised input levels.
  - +0x0C COAL: RW; [7:0] COUNT_TH, [31:16] TIMEOUT.
  - +0x10 MODE: RW; 0 = rising-edge, 1 = level.
- Read: rd_ce with a hit latches the data into ip2bus_data_o on the next edge. In every other cycle ip2bus_data_o is 0, so the parent can OR it with other slaves.
- Sync: each source passes through SYNC_STAGES flops. Edge mode adds one more flop for rising-edge detect.
- Latency: input rise to STATUS set is SYNC_STAGES+1 cycles. STATUS change to int_pending_o / int_ptp_o (without coalescing) is 1 further cycle.
- Edge mode: a detected rising edge sets STATUS[i]. A W1C clears it.
- Level mode: STATUS[i] is set every cycle the synced level is high. W1C only takes effect once the level is low.
- Simultaneous set and W1C on the same bit in one cycle: set wins.
- MASK does not gate STATUS capture. It gates only int_pending_o and int_ptp_o.
- Without coalescing: int_ptp_o = |(STATUS & MASK), registered.

Optional Feature:
- Macro: PTP_INTC_COALESCE_EN.
- Defined: two-state FSM, IDLE and HOLD.
  - IDLE: the first cycle with any newly set masked STATUS bit goes to HOLD. The event counter loads 1 and the timer loads 0.
  - HOLD: each cycle with new masked set bits increments the counter (saturates at 255). The timer increments each cycle, saturating at 2^TMR_W-1.
  - int_ptp_o asserts when count >= COUNT_TH, or when TIMEOUT != 0 and timer >= TIMEOUT.
  - COUNT_TH of 0 or 1 gives immediate assertion.
  - Once asserted, int_ptp_o holds until (STATUS & MASK) == 0. The FSM then returns to IDLE and clears the counter and timer.
  - Writing COAL while in HOLD takes effect on the next comparison.
- Undefined: the COAL register reads 0 and ignores writes, there is no FSM, and int_ptp_o = registered |(STATUS & MASK).

Decomposition:
- Package ptp_intc_pkg holds:
  - register offset constants (STATUS, MASK, RAW, COAL, MODE);
  - COAL field positions and reset value;
  - FSM state encoding.
- Sub-module ptp_intc_sync: a one-source synchroniser plus rising-edge detector, instantiated NUM_SRC times with a generate loop.

Test Plan:
1. Reset with MASK=0xFF, MODE=0. Pulse int_src_i[3] high for 1 cycle (>=1 bus clock wide) -> STATUS reads 0x08 after SYNC_STAGES+1 cycles and int_ptp_o=1 one cycle later. Write 0x08 to +0x00 -> STATUS 0 and int_ptp_o=0.
2. MODE[5]=1, hold src[5] high. A W1C of 0x20 leaves STATUS=0x20. Drop src[5], then W1C again -> STATUS 0.
3. MASK=0x00 and pulse src[0] -> STATUS=0x01 and int_ptp_o stays 0. Write MASK=0x01 -> int_ptp_o=1 the next cycle.
4. An edge on src[2] in the same cycle as a W1C of bit 2 -> STATUS[2] remains 1.
5. With PTP_INTC_COALESCE_EN, COAL=0x0000_0003:
   - 2 events -> int_ptp_o stays 0; the 3rd event -> int_ptp_o=1.
   - Then COAL=0x0064_0010 and 1 event -> int_ptp_o=1 exactly 100 cycles after entering HOLD.
6. Read at +0x14 and at 32'h400 -> ip2bus_data_o=0. Assert reset mid-HOLD -> all outputs 0 immediately and COAL reads 0x0000_0001.
